// File: rtl/buzzer_tone_gen.sv
// Note-code to square-wave buzzer driver. Each note code selects a half-period
// in 1 us ticks, and pitch changes are deferred to whole-period boundaries.
module buzzer_tone_gen #(
  parameter int PRESCALE = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [5:0] note_in,
  output logic       buzzer,
  output logic       playing,
  output logic [5:0] cur_note,
  output logic       period_end
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t          state, next_state;
  logic [PS_W-1:0] prescaler;
  logic [10:0]     phase_cnt;
  logic [10:0]     half;
  logic            note_valid;
  logic            tick;
  logic            phase_end;
  logic            load;
  logic            buzzer_d;
  logic            period_end_d;
  logic [5:0]      cur_note_d;

  // Half-period in 1 us ticks: round(500000 / (261.63 * 2^((n-1)/12))).
  function automatic logic [10:0] half_lut(input logic [5:0] n);
    case (n)
      6'd1:  half_lut = 11'd1911;  6'd2:  half_lut = 11'd1804;
      6'd3:  half_lut = 11'd1703;  6'd4:  half_lut = 11'd1607;
      6'd5:  half_lut = 11'd1517;  6'd6:  half_lut = 11'd1432;
      6'd7:  half_lut = 11'd1351;  6'd8:  half_lut = 11'd1276;
      6'd9:  half_lut = 11'd1204;  6'd10: half_lut = 11'd1136;
      6'd11: half_lut = 11'd1073;  6'd12: half_lut = 11'd1012;
      6'd13: half_lut = 11'd956;   6'd14: half_lut = 11'd902;
      6'd15: half_lut = 11'd851;   6'd16: half_lut = 11'd804;
      6'd17: half_lut = 11'd758;   6'd18: half_lut = 11'd716;
      6'd19: half_lut = 11'd676;   6'd20: half_lut = 11'd638;
      6'd21: half_lut = 11'd602;   6'd22: half_lut = 11'd568;
      6'd23: half_lut = 11'd536;   6'd24: half_lut = 11'd506;
      6'd25: half_lut = 11'd478;   6'd26: half_lut = 11'd451;
      6'd27: half_lut = 11'd426;   6'd28: half_lut = 11'd402;
      6'd29: half_lut = 11'd379;   6'd30: half_lut = 11'd358;
      6'd31: half_lut = 11'd338;   6'd32: half_lut = 11'd319;
      6'd33: half_lut = 11'd301;   6'd34: half_lut = 11'd284;
      6'd35: half_lut = 11'd268;   6'd36: half_lut = 11'd253;
      default: half_lut = 11'd0;
    endcase
  endfunction

  assign note_valid = (note_in != 6'd0) && (note_in <= 6'd36);
  assign tick       = (prescaler == PS_W'(PRESCALE - 1));
  assign phase_end  = (state != IDLE) && tick && (phase_cnt == half - 11'd1);
  assign playing    = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // enable low wins over everything, including a phase end in the same cycle.
  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned (no latch).
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (note_valid) next_state = HIGH;
        HIGH:    if (phase_end)  next_state = LOW;
        LOW:     if (phase_end)  next_state = note_valid ? HIGH : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    load         = (next_state == HIGH) && (state != HIGH);
    buzzer_d     = (next_state == HIGH);
    period_end_d = enable && (state == LOW) && phase_end;
    cur_note_d   = cur_note;
    if (load)                    cur_note_d = note_in;
    else if (next_state == IDLE) cur_note_d = 6'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzzer     <= 1'b0;
      period_end <= 1'b0;
      cur_note   <= 6'd0;
      half       <= 11'd0;
      prescaler  <= '0;
      phase_cnt  <= 11'd0;
    end else begin
      buzzer     <= buzzer_d;
      period_end <= period_end_d;
      cur_note   <= cur_note_d;
      if (load) half <= half_lut(note_in);

      // Restarting the prescaler on a fresh start keeps the first phase exact.
      if ((state == IDLE && load) || tick) prescaler <= '0;
      else                                 prescaler <= prescaler + PS_W'(1);

      if (state == IDLE || phase_end) phase_cnt <= 11'd0;
      else if (tick)                  phase_cnt <= phase_cnt + 11'd1;
    end
  end

endmodule
